// File: rtl/ascon_permutation_ctrl.sv
// Iterative Ascon-p[rnd] sequencer. It holds the 320-bit state and applies one
// round per clock through an external round datapath (constant addition ->
// substitution -> linear diffusion). Requests and results use valid/ready
// handshakes.
// Optional feature: define ASCON_PERM_ABORT_EN to add abort_i, which cancels a
// request that is running or waiting for its result to be taken.
module ascon_permutation_ctrl #(
  parameter int unsigned MAX_ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef ASCON_PERM_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [4:0]   num_rounds_i,
  input  logic [319:0] state_i,
  output logic [3:0]   rnd_o,
  output logic [319:0] round_state_o,
  input  logic [319:0] round_state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] state_o,
  output logic         busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] MaxRounds = 5'(MAX_ROUNDS);

  logic [1:0]   fsm_q, fsm_d;
  logic [319:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [4:0]   rounds_left_q, rounds_left_d;
  logic [4:0]   n_sat;
  logic         abort;

`ifdef ASCON_PERM_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Oversized round requests saturate to the full LUT length.
  assign n_sat = (num_rounds_i > MaxRounds) ? MaxRounds : num_rounds_i;

  // Next-state logic: accept in IDLE, one round per cycle in RUN, hold in DONE.
  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    rnd_d         = rnd_q;
    rounds_left_d = rounds_left_q;
    case (fsm_q)
      IDLE: begin
        // abort is deliberately ignored here so a simultaneous request wins.
        if (in_valid_i) begin
          state_d = state_i;
          if (n_sat == 5'd0) begin
            fsm_d = DONE;
          end else begin
            // Final round always uses the last LUT entry, so start at MAX-n.
            rnd_d         = 4'(MaxRounds - n_sat);
            rounds_left_d = n_sat;
            fsm_d         = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          fsm_d         = IDLE;
          state_d       = '0;
          rnd_d         = '0;
          rounds_left_d = '0;
        end else begin
          state_d       = round_state_i;
          rnd_d         = rnd_q + 4'd1;
          rounds_left_d = rounds_left_q - 5'd1;
          if (rounds_left_q == 5'd1) begin
            fsm_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          fsm_d         = IDLE;
          state_d       = '0;
          rnd_d         = '0;
          rounds_left_d = '0;
        end else if (out_ready_i) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= IDLE;
      state_q       <= '0;
      rnd_q         <= '0;
      rounds_left_q <= '0;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      rnd_q         <= rnd_d;
      rounds_left_q <= rounds_left_d;
    end
  end

  // Outputs come straight from registers; no input-to-output combinational path.
  always_comb begin
    in_ready_o    = (fsm_q == IDLE);
    busy_o        = (fsm_q == RUN);
    out_valid_o   = (fsm_q == DONE);
    rnd_o         = rnd_q;
    round_state_o = state_q;
    state_o       = state_q;
  end

endmodule
